// File: rtl/dma_cmdq_pkg.sv
// dma_cmdq_pkg: shared types for the DMA dispatcher, command queue and
// transfer controller (command layout, queue status bundle, widths).
package dma_cmdq_pkg;

    localparam int CMDQ_SRC_W   = 48;
    localparam int CMDQ_DST_W   = 48;
    localparam int CMDQ_LEN_W   = 40;
    localparam int CMDQ_USEDW_W = 8;
    localparam int CMDQ_DEPTH   = 128;
    localparam int CMD_W = CMDQ_SRC_W + CMDQ_DST_W + CMDQ_LEN_W;

    typedef struct packed {
        logic [CMDQ_SRC_W-1:0] src;
        logic [CMDQ_DST_W-1:0] dst;
        logic [CMDQ_LEN_W-1:0] len;
    } dma_ctrl_cmd_t;

    typedef struct packed {
        logic                    empty;
        logic                    full;
        logic                    underflow;
        logic                    overflow;
        logic [CMDQ_USEDW_W-1:0] usedw;
    } cmdq_status_t;

endpackage

// File: rtl/dma_cmdq_ram.sv
// dma_cmdq_ram: DEPTH x WIDTH command storage with a show-ahead head register.
// Ports: wr_en/wr_addr/wr_data write; ld_en reloads head from mem[rd_addr] or wr_data (ld_bypass).
module dma_cmdq_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 136,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sclr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ld_en,
    input  logic             ld_bypass,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Bypass covers the case where the next head is the entry being
    // written this same cycle (empty queue, or one-deep with pop).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   head <= '0;
        else if (sclr)  head <= '0;
        else if (ld_en) head <= ld_bypass ? wr_data : mem[rd_addr];
    end

endmodule

// File: rtl/dma_cmd_queue.sv
// dma_cmd_queue: command FIFO from DMA dispatcher to transfer controller.
// Ports: new_cmd/cmd_in push, cmd_pop/cmd_out show-ahead pop, status flags, usedw, cmd_accept_cnt.
module dma_cmd_queue
    import dma_cmdq_pkg::*;
#(
    parameter int SRC_ADDR_WIDTH    = CMDQ_SRC_W,
    parameter int DST_ADDR_WIDTH    = CMDQ_DST_W,
    parameter int XFER_LENGTH_WIDTH = CMDQ_LEN_W,
    parameter int CMDQ_USEDW_WIDTH  = CMDQ_USEDW_W,
    parameter int DEPTH             = CMDQ_DEPTH,
    localparam int CW_CMD = SRC_ADDR_WIDTH + DST_ADDR_WIDTH + XFER_LENGTH_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sclr,
    input  logic                        new_cmd,
    input  logic [CW_CMD-1:0]           cmd_in,
    input  logic                        cmd_pop,
    output logic [CW_CMD-1:0]           cmd_out,
    output logic                        empty,
    output logic                        full,
    output logic                        underflow,
    output logic                        overflow,
    output logic [CMDQ_USEDW_WIDTH-1:0] usedw,
    output logic [31:0]                 cmd_accept_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH >= (1 << CMDQ_USEDW_WIDTH)) begin : g_bad_usedw
        $error("dma_cmd_queue: DEPTH does not fit in usedw");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign usedw = CMDQ_USEDW_WIDTH'(count);

    // A pop frees a slot, so a push into a full queue is accepted then.
    assign pop  = cmd_pop && !empty;
    assign push = new_cmd && (!full || cmd_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            underflow      <= 1'b0;
            overflow       <= 1'b0;
            cmd_accept_cnt <= '0;
        end else if (sclr) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            underflow      <= 1'b0;
            overflow       <= 1'b0;
            cmd_accept_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push) cmd_accept_cnt <= cmd_accept_cnt + 32'd1;
            if (cmd_pop && empty)            underflow <= 1'b1;
            if (new_cmd && full && !cmd_pop) overflow  <= 1'b1;
        end
    end

    dma_cmdq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (CW_CMD),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclr      (sclr),
        .wr_en     (push && !sclr),
        .wr_addr   (wr_ptr),
        .wr_data   (cmd_in),
        .ld_en     (pop || (push && empty)),
        .ld_bypass (count <= CW'(1)),
        .rd_addr   (ptr_inc(rd_ptr)),
        .head      (cmd_out)
    );

endmodule

// File: tb/tb_dma_cmd_queue.sv
// tb_dma_cmd_queue: directed self-checking bench for dma_cmd_queue.
// Linear stimulus with immediate-assertion checks against hand-computed values.
module tb_dma_cmd_queue;

    logic         clk;
    logic         reset_n;
    logic         sclr;
    logic         new_cmd;
    logic [135:0] cmd_in;
    logic         cmd_pop;
    logic [135:0] cmd_out;
    logic         empty;
    logic         full;
    logic         underflow;
    logic         overflow;
    logic [7:0]   usedw;
    logic [31:0]  cmd_accept_cnt;

    int checks   = 0;
    int failures = 0;

    dma_cmd_queue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sclr           (sclr),
        .new_cmd        (new_cmd),
        .cmd_in         (cmd_in),
        .cmd_pop        (cmd_pop),
        .cmd_out        (cmd_out),
        .empty          (empty),
        .full           (full),
        .underflow      (underflow),
        .overflow       (overflow),
        .usedw          (usedw),
        .cmd_accept_cnt (cmd_accept_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [135:0] mk(input int i);
        return {48'(i * 32'h1000), 48'(i * 32'h2000), 40'(i * 64)};
    endfunction

    task automatic check(input string tag, input logic [135:0] obs,
                         input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".empty"}, 136'(empty), 136'(1));
        check({tag, ".full"}, 136'(full), 136'(0));
        check({tag, ".usedw"}, 136'(usedw), 136'(0));
        check({tag, ".underflow"}, 136'(underflow), 136'(0));
        check({tag, ".overflow"}, 136'(overflow), 136'(0));
        check({tag, ".acc"}, 136'(cmd_accept_cnt), 136'(0));
        check({tag, ".cmd_out"}, cmd_out, 136'(0));
    endtask

    task automatic do_sclr();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        sclr    = 1'b0;
        new_cmd = 1'b0;
        cmd_in  = '0;
        cmd_pop = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check_idle("reset");

        // three pushes, three pops
        for (int i = 1; i <= 3; i++) begin
            new_cmd = 1'b1;
            cmd_in  = mk(i);
            tick();
        end
        new_cmd = 1'b0;
        check("t1.usedw", 136'(usedw), 136'(3));
        check("t1.empty", 136'(empty), 136'(0));
        check("t1.head", cmd_out, mk(1));
        check("t1.acc", 136'(cmd_accept_cnt), 136'(3));
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("t1.pop%0d", i), cmd_out, mk(i));
            cmd_pop = 1'b1;
            tick();
        end
        cmd_pop = 1'b0;
        check("t1.empty_end", 136'(empty), 136'(1));
        check("t1.usedw_end", 136'(usedw), 136'(0));

        // fill to DEPTH, then overflow
        do_sclr();
        for (int i = 1; i <= 128; i++) begin
            new_cmd = 1'b1;
            cmd_in  = mk(i);
            tick();
        end
        check("t2.full", 136'(full), 136'(1));
        check("t2.usedw", 136'(usedw), 136'(128));
        check("t2.ovf_pre", 136'(overflow), 136'(0));
        cmd_in = mk(129);
        tick();
        new_cmd = 1'b0;
        check("t2.overflow", 136'(overflow), 136'(1));
        check("t2.usedw_ovf", 136'(usedw), 136'(128));
        check("t2.acc", 136'(cmd_accept_cnt), 136'(128));
        for (int i = 1; i <= 128; i++) begin
            check($sformatf("t2.drain%0d", i), cmd_out, mk(i));
            cmd_pop = 1'b1;
            tick();
        end
        cmd_pop = 1'b0;
        check("t2.empty_end", 136'(empty), 136'(1));
        check("t2.ovf_held", 136'(overflow), 136'(1));
        do_sclr();
        check_idle("t2.sclr");

        // full queue, push and pop together
        for (int i = 1; i <= 128; i++) begin
            new_cmd = 1'b1;
            cmd_in  = mk(200 + i);
            tick();
        end
        cmd_in  = mk(999);
        cmd_pop = 1'b1;
        tick();
        new_cmd = 1'b0;
        cmd_pop = 1'b0;
        check("t3.usedw", 136'(usedw), 136'(128));
        check("t3.full", 136'(full), 136'(1));
        check("t3.overflow", 136'(overflow), 136'(0));
        for (int i = 2; i <= 129; i++) begin
            check($sformatf("t3.drain%0d", i), cmd_out,
                  (i == 129) ? mk(999) : mk(200 + i));
            cmd_pop = 1'b1;
            tick();
        end
        cmd_pop = 1'b0;
        check("t3.empty_end", 136'(empty), 136'(1));
        do_sclr();

        // pop while empty, then pushes
        cmd_pop = 1'b1;
        tick();
        cmd_pop = 1'b0;
        check("t4.underflow", 136'(underflow), 136'(1));
        check("t4.usedw0", 136'(usedw), 136'(0));
        new_cmd = 1'b1;
        cmd_in  = mk(7);
        tick();
        new_cmd = 1'b0;
        check("t4.usedw1", 136'(usedw), 136'(1));
        check("t4.head7", cmd_out, mk(7));
        check("t4.unf_held", 136'(underflow), 136'(1));
        do_sclr();
        // push plus pop into empty: push taken, pop flagged
        new_cmd = 1'b1;
        cmd_pop = 1'b1;
        cmd_in  = mk(8);
        tick();
        new_cmd = 1'b0;
        cmd_pop = 1'b0;
        check("t4.pp_empty", 136'(empty), 136'(0));
        check("t4.pp_usedw", 136'(usedw), 136'(1));
        check("t4.pp_head", cmd_out, mk(8));
        check("t4.pp_unf", 136'(underflow), 136'(1));
        // sclr beats a same-cycle push
        sclr    = 1'b1;
        new_cmd = 1'b1;
        cmd_in  = mk(9);
        tick();
        sclr    = 1'b0;
        new_cmd = 1'b0;
        check_idle("t4.sclr");

        // async reset mid-burst
        for (int i = 1; i <= 2; i++) begin
            new_cmd = 1'b1;
            cmd_in  = mk(i);
            tick();
        end
        check("t5.usedw_pre", 136'(usedw), 136'(2));
        new_cmd = 1'b0;
        reset_n = 1'b0;
        #1;
        check_idle("t5.async");
        tick();
        reset_n = 1'b1;
        new_cmd = 1'b1;
        cmd_in  = mk(50);
        tick();
        new_cmd = 1'b0;
        check("t5.usedw", 136'(usedw), 136'(1));
        check("t5.acc", 136'(cmd_accept_cnt), 136'(1));
        check("t5.head", cmd_out, mk(50));
        do_sclr();

        // streaming push every cycle, pop from cycle 2
        for (int k = 1; k <= 1000; k++) begin
            new_cmd = 1'b1;
            cmd_in  = mk(k);
            cmd_pop = (k >= 2);
            if (k >= 2) check($sformatf("t6.data%0d", k), cmd_out, mk(k - 1));
            tick();
            check($sformatf("t6.usedw%0d", k), 136'(usedw), 136'(1));
        end
        new_cmd = 1'b0;
        cmd_pop = 1'b0;
        check("t6.acc", 136'(cmd_accept_cnt), 136'(1000));
        check("t6.underflow", 136'(underflow), 136'(0));
        check("t6.overflow", 136'(overflow), 136'(0));
        check("t6.full", 136'(full), 136'(0));
        check("t6.head", cmd_out, mk(1000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
